// File: rtl/ifmap_diag_tx_pkg.sv
// Shared types and constants for the ifmap diagonal NoC transmitter.
// PE[i][j] listens on diagonal i+j, giving PE_ROWS+PE_COLS-1 diagonals.
package ifmap_diag_tx_pkg;

  localparam int PE_ROWS    = 6;
  localparam int PE_COLS    = 7;
  localparam int NUM_DIAG   = PE_ROWS + PE_COLS - 1;
  localparam int PKT_DATA_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [PKT_DATA_W-1:0] data;
  } PE_IN_PACKET;

  typedef struct packed {
    PE_IN_PACKET [NUM_DIAG-1:0] diagonal_bus;
  } DIAGONAL_BUS_PACKET;

endpackage

// File: rtl/ifmap_diag_tx_fifo.sv
// Per-diagonal synchronous FIFO with registered occupancy.
// Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
module diag_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [AW:0]       r_cnt;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign empty  = (r_cnt == '0);
  assign head   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

endmodule

// File: rtl/ifmap_diag_tx.sv
// Ifmap NoC transmitter: demuxes tagged words into per-diagonal FIFOs and
// issues them on the 12 diagonal buses under pe_full back-pressure.
module ifmap_diag_tx
  import ifmap_diag_tx_pkg::*;
#(
  parameter int DATA_W     = PKT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_DIAG-1:0]           diag_en,
  input  logic [LEN_W-1:0]              load_len,
  input  logic                          in_valid,
  input  logic [3:0]                    in_diag,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic [PE_ROWS-1:0][PE_COLS-1:0] pe_full,
  output DIAGONAL_BUS_PACKET            diagonal_bus_packet,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          err_drop
);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [NUM_DIAG-1:0] r_en;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_acc  [NUM_DIAG];
  logic [LEN_W-1:0]    r_sent [NUM_DIAG];

  logic [NUM_DIAG-1:0] w_full;
  logic [NUM_DIAG-1:0] w_empty;
  logic [NUM_DIAG-1:0] w_push;
  logic [NUM_DIAG-1:0] w_send;
  logic [NUM_DIAG-1:0] w_blocked;
  logic [DATA_W-1:0]   w_head [NUM_DIAG];

  logic       w_stream;
  logic       w_diag_ok;
  logic [3:0] w_idx;
  logic       w_accept_ok;
  logic       w_all_sent;

  assign w_stream    = (r_state == ST_STREAM);
  assign w_diag_ok   = (in_diag < 4'(NUM_DIAG));
  assign w_idx       = w_diag_ok ? in_diag : '0;
  assign w_accept_ok = w_diag_ok & r_en[w_idx] & (r_acc[w_idx] < r_len);
  assign in_ready    = w_stream & w_accept_ok & ~w_full[w_idx];
  assign err_drop    = w_stream & in_valid & ~w_accept_ok;
  assign busy        = (r_state != ST_IDLE);
  assign tx_done     = (r_state == ST_DONE);

  always_comb begin
    w_push = '0;
    if (in_valid && in_ready) w_push[w_idx] = 1'b1;
  end

  always_comb begin
    w_blocked = '0;
    for (int unsigned i = 0; i < PE_ROWS; i++)
      for (int unsigned j = 0; j < PE_COLS; j++)
        w_blocked[i+j] = w_blocked[i+j] | pe_full[i][j];
  end

  for (genvar d = 0; d < NUM_DIAG; d++) begin : g_diag
    diag_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[d]),
      .pop   (w_send[d]),
      .wdata (in_data),
      .full  (w_full[d]),
      .empty (w_empty[d]),
      .head  (w_head[d])
    );
    assign w_send[d] = w_stream & r_en[d] & ~w_empty[d] & ~w_blocked[d];
  end

  always_comb begin
    diagonal_bus_packet = '0;
    for (int unsigned d = 0; d < NUM_DIAG; d++) begin
      diagonal_bus_packet.diagonal_bus[d].valid = w_send[d];
      if (w_send[d]) diagonal_bus_packet.diagonal_bus[d].data = PKT_DATA_W'(w_head[d]);
    end
  end

  // Completion looks ahead by this cycle's sends, so DONE follows the last issue directly.
  always_comb begin
    w_all_sent = 1'b1;
    for (int unsigned d = 0; d < NUM_DIAG; d++)
      if (r_en[d] && (r_sent[d] + LEN_W'(w_send[d]) != r_len)) w_all_sent = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_all_sent) w_state_nxt = ST_DONE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_en    <= '0;
      r_len   <= '0;
      for (int unsigned d = 0; d < NUM_DIAG; d++) begin
        r_acc[d]  <= '0;
        r_sent[d] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start) begin
        r_en  <= diag_en;
        r_len <= load_len;
        for (int unsigned d = 0; d < NUM_DIAG; d++) begin
          r_acc[d]  <= '0;
          r_sent[d] <= '0;
        end
      end else if (w_stream) begin
        for (int unsigned d = 0; d < NUM_DIAG; d++) begin
          if (w_push[d]) r_acc[d]  <= r_acc[d] + LEN_W'(1);
          if (w_send[d]) r_sent[d] <= r_sent[d] + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ifmap_diag_tx.sv
// Randomized bench for ifmap_diag_tx against a queue-based round model.
module tb_ifmap_diag_tx;
  import ifmap_diag_tx_pkg::*;

  localparam int DEPTH = 4;
  localparam int ND    = NUM_DIAG;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ND-1:0]      diag_en;
  logic [7:0]         load_len;
  logic               in_valid;
  logic [3:0]         in_diag;
  logic [7:0]         in_data;
  logic               in_ready;
  logic [5:0][6:0]    pe_full;
  DIAGONAL_BUS_PACKET bus_pkt;
  logic               busy;
  logic               tx_done;
  logic               err_drop;

  int n_checks = 0;
  int n_errors = 0;

  // Round model: 0 idle, 1 streaming, 2 done
  int            m_st = 0;
  logic [ND-1:0] m_en = '0;
  int            m_len = 0;
  int            m_acc [ND];
  int            m_sent [ND];
  logic [7:0]    m_q [ND][$];

  ifmap_diag_tx #(
    .DATA_W     (8),
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .diag_en             (diag_en),
    .load_len            (load_len),
    .in_valid            (in_valid),
    .in_diag             (in_diag),
    .in_data             (in_data),
    .in_ready            (in_ready),
    .pe_full             (pe_full),
    .diagonal_bus_packet (bus_pkt),
    .busy                (busy),
    .tx_done             (tx_done),
    .err_drop            (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_eval(output logic rdy, output logic err,
                            output logic [ND*9-1:0] bus, output logic [ND-1:0] snd);
    logic [ND-1:0] blk;
    logic ok;
    blk = '0;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        if (pe_full[i][j]) blk[i+j] = 1'b1;
    ok  = (in_diag < 12) && m_en[in_diag] && (m_acc[in_diag] < m_len);
    rdy = (m_st == 1) && ok && (m_q[in_diag].size() < DEPTH);
    err = (m_st == 1) && in_valid && !ok;
    bus = '0;
    for (int d = 0; d < ND; d++) begin
      snd[d] = (m_st == 1) && m_en[d] && (m_q[d].size() > 0) && !blk[d];
      if (snd[d]) bus[d*9 +: 9] = {1'b1, m_q[d][0]};
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < ND; d++) begin
      m_q[d].delete();
      m_acc[d]  = 0;
      m_sent[d] = 0;
    end
  endtask

  task automatic cycle();
    logic rdy, err;
    logic [ND*9-1:0] bus;
    logic [ND-1:0] snd;
    bit all;
    @(negedge clk);
    model_eval(rdy, err, bus, snd);
    check("in_ready", 128'(in_ready), 128'(rdy));
    check("err_drop", 128'(err_drop), 128'(err));
    check("bus",      128'(bus_pkt),  128'(bus));
    check("busy",     128'(busy),     128'(m_st != 0));
    check("tx_done",  128'(tx_done),  128'(m_st == 2));
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_en = '0; m_len = 0;
      model_clear();
    end else begin
      case (m_st)
        0: if (start) begin
             m_st = 1; m_en = diag_en; m_len = int'(load_len);
             model_clear();
           end
        1: begin
             for (int d = 0; d < ND; d++)
               if (snd[d]) begin
                 void'(m_q[d].pop_front());
                 m_sent[d]++;
               end
             if (in_valid && rdy) begin
               m_q[in_diag].push_back(in_data);
               m_acc[in_diag]++;
             end
             all = 1;
             for (int d = 0; d < ND; d++)
               if (m_en[d] && m_sent[d] != m_len) all = 0;
             if (all) m_st = 2;
           end
        default: m_st = 0;
      endcase
    end
    #1;
  endtask

  task automatic run_round(input logic [ND-1:0] en, input int len,
                           input logic [41:0] hold_mask, input int hold_cyc,
                           input bit rand_pf, input int err_pct, input int abort_at,
                           input logic [8:0] fix_data);
    int cyc;
    int need[$];
    start = 1'b1; diag_en = en; load_len = 8'(len); in_valid = 1'b0; pe_full = '0;
    cycle();
    start = 1'b0; diag_en = ND'($urandom); load_len = 8'($urandom);
    cyc = 0;
    while (m_st != 0 && cyc < 3000) begin
      pe_full = (cyc < hold_cyc) ? hold_mask : '0;
      if (rand_pf && $urandom_range(3) == 0) pe_full = pe_full | (42'(1) << $urandom_range(41));
      start = ($urandom_range(7) == 0);
      need.delete();
      for (int d = 0; d < ND; d++)
        if (m_en[d] && m_acc[d] < m_len) need.push_back(d);
      if (need.size() > 0 && $urandom_range(99) >= err_pct) begin
        in_valid = ($urandom_range(3) != 0);
        in_diag  = 4'(need[$urandom_range(need.size() - 1)]);
      end else begin
        in_valid = 1'b1;
        in_diag  = 4'($urandom_range(15));
      end
      in_data = fix_data[8] ? fix_data[7:0] : 8'($urandom);
      if (abort_at > 0 && cyc == abort_at) rst = 1'b1;
      cycle();
      rst = 1'b0;
      cyc++;
    end
    if (cyc >= 3000) begin
      check("round_timeout", 128'(1), 128'(0));
      rst = 1'b1;
      cycle();
      rst = 1'b0;
    end
    in_valid = 1'b0; start = 1'b0; pe_full = '0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; diag_en = '0; load_len = '0;
    in_valid = 1'b0; in_diag = '0; in_data = '0; pe_full = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;
    cycle();

    run_round(12'h001, 1, '0, 0, 1'b0, 0, 0, 9'h1A5);
    run_round(12'h020, 3, 42'(1) << 17, 10, 1'b0, 0, 0, 9'h000);
    run_round(12'h800, 6, 42'(1) << 41, 20, 1'b0, 0, 0, 9'h000);
    run_round(12'hFFF, 2, '0, 0, 1'b0, 0, 0, 9'h000);
    run_round(12'hFF7, 2, '0, 0, 1'b1, 40, 0, 9'h000);
    run_round(12'hFFF, 4, 42'h3FF_FFFF_FFFF, 8, 1'b0, 0, 12, 9'h000);
    run_round(12'h0F0, 3, '0, 0, 1'b1, 10, 0, 9'h000);
    run_round(12'h000, 0, '0, 0, 1'b0, 0, 0, 9'h000);
    run_round(12'h5A5, 0, '0, 0, 1'b0, 20, 0, 9'h000);
    for (int r = 0; r < 8; r++)
      run_round(ND'($urandom), $urandom_range(5), '0, 0, 1'b1, 20, 0, 9'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
